// File: rtl/tinycpu_pkg.sv
// Shared tinycpu definitions: fetch FSM encodings, reset PC default, instruction width.
// Pure declarations; no logic.
package tinycpu_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    FETCH        = 3'd1,
    WAIT_MEM     = 3'd2,
    PRESENT      = 3'd3,
    WAIT_ACK_LOW = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding word reads, instruction held on DOR/data_out until acked.
// Reset-to-DOR is 3 cycles with a one-cycle memory; ack must drop before the next fetch starts.
module instruction_fetch
  import tinycpu_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pc_load,
  input  logic [31:0]        pc_load_value,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_valid,
  output logic               DOR,
  output logic [INSTR_W-1:0] data_out,
  input  logic               ack_from_next,
  output logic [31:0]        pc_out,
  output logic [15:0]        retry_count
);

  localparam int TIMER_W = (MEM_TIMEOUT <= 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MEM_TIMEOUT - 1);

  fetch_state_t       state, state_next;
  logic [31:0]        pc;
  logic [31:0]        redirect_pc;
  logic               redirect_pending;
  logic [TIMER_W-1:0] timer;

  logic               timeout;
  logic               accept;
  logic               advance;
  logic               consume_redirect;

  always_comb begin
    state_next       = state;
    timeout          = 1'b0;
    accept           = 1'b0;
    advance          = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = FETCH;
      end
      FETCH: begin
        state_next = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          accept     = 1'b1;
          state_next = PRESENT;
        end else if (timer == TIMER_LAST) begin
          timeout    = 1'b1;
          state_next = FETCH;
        end
      end
      PRESENT: begin
        if (ack_from_next) begin
          advance    = 1'b1;
          state_next = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_from_next) state_next = enable ? FETCH : IDLE;
      end
      default: state_next = IDLE;
    endcase
    // FETCH never loops on itself, so any entry into FETCH is a fresh transition.
    consume_redirect = redirect_pending && (state_next == FETCH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      redirect_pc      <= 32'h0;
      redirect_pending <= 1'b0;
      timer            <= '0;
      DOR              <= 1'b0;
      data_out         <= '0;
      pc_out           <= 32'h0;
      retry_count      <= 16'h0;
    end else begin
      state <= state_next;

      if (consume_redirect) pc <= redirect_pc;
      else if (advance)     pc <= pc + 32'd4;

      // A load coinciding with consumption survives as the next target.
      if (pc_load) begin
        redirect_pending <= 1'b1;
        redirect_pc      <= pc_load_value & 32'hFFFF_FFFC;
      end else if (consume_redirect) begin
        redirect_pending <= 1'b0;
      end

      if (state == FETCH)                      timer <= '0;
      else if (state == WAIT_MEM && !mem_valid) timer <= timer + TIMER_W'(1);

      if (accept) begin
        data_out <= mem_rdata;
        pc_out   <= pc;
        DOR      <= 1'b1;
      end else if (advance) begin
        DOR <= 1'b0;
      end

      if (timeout && retry_count != 16'hFFFF) retry_count <= retry_count + 16'd1;
    end
  end

  assign mem_req  = (state == FETCH);
  assign mem_addr = (state == FETCH) ? pc[ADDR_W+1:2] : '0;

endmodule
